// File: rtl/x_micro_sequencer_loader_if.sv
// Bus bundle between the host-command loader and its neighbours: UART rx/tx byte
// streams plus the sequencer's program write port, busy flag and start pulse.
interface x_micro_sequencer_loader_if;
  logic        i_rx_valid;
  logic [7:0]  i_rx_data;
  logic        o_rx_ready;
  logic        o_tx_valid;
  logic [7:0]  o_tx_data;
  logic        i_tx_ready;
  logic        i_busy;
  logic        o_wen;
  logic [3:0]  o_wcmd;
  logic [35:0] o_wdata;
  logic [8:0]  o_waddr;
  logic        o_start;

  modport master (
    input  i_rx_valid, i_rx_data, i_tx_ready, i_busy,
    output o_rx_ready, o_tx_valid, o_tx_data, o_wen, o_wcmd, o_wdata, o_waddr, o_start
  );

  modport slave (
    output i_rx_valid, i_rx_data, i_tx_ready, i_busy,
    input  o_rx_ready, o_tx_valid, o_tx_data, o_wen, o_wcmd, o_wdata, o_waddr, o_start
  );
endinterface

// File: rtl/x_micro_sequencer_loader.sv
// Host-command parser: turns a UART byte stream into program-RAM writes, start
// requests and status queries, answering each command with one response byte.
module x_micro_sequencer_loader #(
  parameter int unsigned TIMEOUT  = 1000000,
  parameter logic [7:0]  ACK_BYTE = 8'h06,
  parameter logic [7:0]  NAK_BYTE = 8'h15
) (
  input logic i_clk,
  input logic i_rst,
  x_micro_sequencer_loader_if.master bus
);

  localparam int unsigned TW = (TIMEOUT > 32'd0) ? $clog2(TIMEOUT + 32'd1) : 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_EXEC = 3'd3,
    S_RESP = 3'd4
  } state_t;

  state_t         r_state;
  logic [2:0]     r_cnt;
  logic           r_is_write;
  logic           r_oor;
  logic [39:0]    r_word;
  logic [8:0]     r_waddr;
  logic [TW-1:0]  r_tmo;
  logic           r_rx_ready;
  logic           r_tx_valid;
  logic [7:0]     r_tx_data;

  logic w_acc;
  logic w_exec_ok;
  logic w_tmo_hit;

  assign w_acc     = bus.i_rx_valid & r_rx_ready;
  // Busy is judged in the EXEC cycle itself, so the strobes gate on it directly.
  assign w_exec_ok = (r_state == S_EXEC) & ~bus.i_busy & (~r_is_write | ~r_oor);
  assign w_tmo_hit = (TIMEOUT != 32'd0) && (r_tmo == TW'(TIMEOUT - 32'd1));

  assign bus.o_rx_ready = r_rx_ready;
  assign bus.o_tx_valid = r_tx_valid;
  assign bus.o_tx_data  = r_tx_data;
  assign bus.o_wen      = w_exec_ok & r_is_write;
  assign bus.o_start    = w_exec_ok & ~r_is_write;
  assign bus.o_waddr    = r_waddr;
  assign bus.o_wcmd     = r_word[3:0];
  assign bus.o_wdata    = r_word[39:4];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_is_write <= 1'b0;
      r_oor      <= 1'b0;
      r_word     <= 40'd0;
      r_waddr    <= 9'd0;
      r_tmo      <= '0;
      r_rx_ready <= 1'b1;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tmo <= '0;
          if (w_acc) begin
            case (bus.i_rx_data)
              8'h01: begin
                r_state    <= S_ADDR;
                r_is_write <= 1'b1;
                r_oor      <= 1'b0;
                r_cnt      <= 3'd0;
              end
              8'h02: begin
                r_state    <= S_EXEC;
                r_is_write <= 1'b0;
                r_rx_ready <= 1'b0;
              end
              8'h03: begin
                r_state    <= S_RESP;
                r_tx_data  <= {7'd0, bus.i_busy};
                r_tx_valid <= 1'b1;
                r_rx_ready <= 1'b0;
              end
              default: begin
                r_state    <= S_RESP;
                r_tx_data  <= NAK_BYTE;
                r_tx_valid <= 1'b1;
                r_rx_ready <= 1'b0;
              end
            endcase
          end
        end
        S_ADDR: begin
          if (w_acc) begin
            r_tmo <= '0;
            if (r_cnt == 3'd0) begin
              r_waddr[7:0] <= bus.i_rx_data;
              r_cnt        <= 3'd1;
            end else begin
              r_waddr[8] <= bus.i_rx_data[0];
              r_oor      <= |bus.i_rx_data[7:1];
              r_cnt      <= 3'd0;
              r_state    <= S_DATA;
            end
          end else if (w_tmo_hit) begin
            r_state <= S_IDLE;
            r_tmo   <= '0;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_DATA: begin
          if (w_acc) begin
            r_tmo  <= '0;
            // Bytes arrive LSB first, so shifting down leaves byte 0 at the bottom.
            r_word <= {bus.i_rx_data, r_word[39:8]};
            if (r_cnt == 3'd4) begin
              r_state    <= S_EXEC;
              r_rx_ready <= 1'b0;
              r_cnt      <= 3'd0;
            end else begin
              r_cnt <= r_cnt + 3'd1;
            end
          end else if (w_tmo_hit) begin
            r_state <= S_IDLE;
            r_tmo   <= '0;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_EXEC: begin
          r_state    <= S_RESP;
          r_tx_valid <= 1'b1;
          r_tx_data  <= w_exec_ok ? ACK_BYTE : NAK_BYTE;
        end
        S_RESP: begin
          if (bus.i_tx_ready) begin
            r_state    <= S_IDLE;
            r_tx_valid <= 1'b0;
            r_rx_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_tx_valid <= 1'b0;
          r_rx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_x_micro_sequencer_loader.sv
// Self-checking bench: directed command table, randomized frames against a
// frame-level reference model, and hand-written stall/timeout/reset sequences.
module tb_x_micro_sequencer_loader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  int wen_total = 0, start_total = 0, tx_total = 0, both_total = 0;
  logic [8:0]  cap_waddr;
  logic [3:0]  cap_wcmd;
  logic [35:0] cap_wdata;

  typedef struct {
    logic [63:0] fr;
    int          len;
    bit          busy;
    bit          ex_wen;
    logic [8:0]  ex_waddr;
    logic [3:0]  ex_wcmd;
    logic [35:0] ex_wdata;
    bit          ex_start;
    logic [7:0]  ex_tx;
  } vec_t;

  x_micro_sequencer_loader_if bus ();

  x_micro_sequencer_loader #(.TIMEOUT(16)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.o_wen) begin
      wen_total++;
      cap_waddr = bus.o_waddr;
      cap_wcmd  = bus.o_wcmd;
      cap_wdata = bus.o_wdata;
    end
    if (bus.o_start) start_total++;
    if (bus.o_tx_valid) tx_total++;
    if (bus.o_wen && bus.o_start) both_total++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [63:0] fr, input int i);
    return fr[63 - 8*i -: 8];
  endfunction

  function automatic vec_t mkv(input logic [63:0] fr, input int len, input bit busy,
                               input bit wen, input logic [8:0] wa, input logic [3:0] wc,
                               input logic [35:0] wd, input bit st, input logic [7:0] tx);
    vec_t v;
    v.fr = fr; v.len = len; v.busy = busy; v.ex_wen = wen; v.ex_waddr = wa;
    v.ex_wcmd = wc; v.ex_wdata = wd; v.ex_start = st; v.ex_tx = tx;
    return v;
  endfunction

  // Frame-level reference: what one complete command should do, from the command rules.
  function automatic vec_t model(input logic [63:0] fr, input int len, input bit busy);
    vec_t v;
    longint unsigned word;
    int addr;
    bit ok;
    v = mkv(fr, len, busy, 1'b0, 9'd0, 4'd0, 36'd0, 1'b0, 8'h15);
    case (byte_at(fr, 0))
      8'h01: begin
        addr = int'(byte_at(fr, 1)) + 256 * int'(byte_at(fr, 2) % 2);
        word = 0;
        for (int k = 0; k < 5; k++) word += longint'(byte_at(fr, 3 + k)) << (8 * k);
        ok = !busy && (byte_at(fr, 2) < 8'd2);
        v.ex_wen = ok;
        v.ex_waddr = 9'(addr);
        v.ex_wcmd = 4'(word % 16);
        v.ex_wdata = 36'(word / 16);
        v.ex_tx = ok ? 8'h06 : 8'h15;
      end
      8'h02: begin
        v.ex_start = !busy;
        v.ex_tx = busy ? 8'h15 : 8'h06;
      end
      8'h03: v.ex_tx = busy ? 8'h01 : 8'h00;
      default: v.ex_tx = 8'h15;
    endcase
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bit acc = 1'b0;
    int n = 0;
    bus.i_rx_valid = 1'b1;
    bus.i_rx_data  = b;
    while (!acc && n < 50) begin
      acc = bus.o_rx_ready;
      @(posedge clk); #1;
      n++;
    end
    bus.i_rx_valid = 1'b0;
    if (!acc) check("rx_accept", 64'(acc), 64'd1);
  endtask

  task automatic wait_tx(output bit seen);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      if (bus.o_tx_valid) seen = 1'b1;
      else begin @(posedge clk); #1; end
    end
  endtask

  task automatic handshake_tx;
    bus.i_tx_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_tx_ready = 1'b0;
    check("tx_valid_drop", 64'(bus.o_tx_valid), 64'd0);
    check("rx_ready_back", 64'(bus.o_rx_ready), 64'd1);
  endtask

  task automatic run_frame(input vec_t v);
    int wen0 = wen_total, st0 = start_total;
    bit seen;
    bus.i_busy = v.busy;
    for (int i = 0; i < v.len; i++) send_byte(byte_at(v.fr, i));
    wait_tx(seen);
    check("tx_seen", 64'(seen), 64'd1);
    if (seen) begin
      check("tx_data", 64'(bus.o_tx_data), 64'(v.ex_tx));
      handshake_tx();
    end
    bus.i_busy = 1'b0;
    check("wen_count", 64'(wen_total - wen0), 64'(v.ex_wen));
    check("start_count", 64'(start_total - st0), 64'(v.ex_start));
    if (v.ex_wen) begin
      check("waddr", 64'(cap_waddr), 64'(v.ex_waddr));
      check("wcmd", 64'(cap_wcmd), 64'(v.ex_wcmd));
      check("wdata", 64'(cap_wdata), 64'(v.ex_wdata));
    end
  endtask

  initial begin
    vec_t tbl [9];
    vec_t v;
    logic [7:0] bb [8];
    logic [63:0] fr;
    int len, wen0, tx0;
    bit seen;

    tbl[0] = mkv(64'h0105002543218709, 8, 1'b0, 1'b1, 9'h005, 4'h5, 36'h098721432, 1'b0, 8'h06);
    tbl[1] = mkv(64'h01FF011122334455, 8, 1'b0, 1'b1, 9'h1FF, 4'h1, 36'h554433221, 1'b0, 8'h06);
    tbl[2] = mkv(64'h0100021122334455, 8, 1'b0, 1'b0, 9'h000, 4'h0, 36'h0,         1'b0, 8'h15);
    tbl[3] = mkv(64'h0105002543218709, 8, 1'b1, 1'b0, 9'h000, 4'h0, 36'h0,         1'b0, 8'h15);
    tbl[4] = mkv(64'h0200000000000000, 1, 1'b0, 1'b0, 9'h000, 4'h0, 36'h0,         1'b1, 8'h06);
    tbl[5] = mkv(64'h0200000000000000, 1, 1'b1, 1'b0, 9'h000, 4'h0, 36'h0,         1'b0, 8'h15);
    tbl[6] = mkv(64'h0300000000000000, 1, 1'b1, 1'b0, 9'h000, 4'h0, 36'h0,         1'b0, 8'h01);
    tbl[7] = mkv(64'h0300000000000000, 1, 1'b0, 1'b0, 9'h000, 4'h0, 36'h0,         1'b0, 8'h00);
    tbl[8] = mkv(64'h7E00000000000000, 1, 1'b0, 1'b0, 9'h000, 4'h0, 36'h0,         1'b0, 8'h15);

    bus.i_rx_valid = 1'b0;
    bus.i_rx_data  = 8'd0;
    bus.i_tx_ready = 1'b0;
    bus.i_busy     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_outputs", {bus.o_tx_valid, bus.o_wen, bus.o_start, bus.o_tx_data,
                            bus.o_waddr, bus.o_wcmd, bus.o_wdata}, 64'd0);
    check("reset_rx_ready", 64'(bus.o_rx_ready), 64'd1);

    for (int i = 0; i < 9; i++) run_frame(tbl[i]);

    // Response stall: output held and input blocked while the transmitter is busy.
    bus.i_busy = 1'b1;
    send_byte(8'h03);
    bus.i_busy = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check("stall_valid", 64'(bus.o_tx_valid), 64'd1);
      check("stall_data", 64'(bus.o_tx_data), 64'h01);
      check("stall_rx_ready", 64'(bus.o_rx_ready), 64'd0);
      @(posedge clk); #1;
    end
    handshake_tx();

    // Timeout: opcode plus three bytes, then exactly TIMEOUT idle cycles.
    wen0 = wen_total; tx0 = tx_total;
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h00); send_byte(8'h25);
    repeat (16) @(posedge clk);
    #1;
    check("timeout_no_tx", 64'(tx_total - tx0), 64'd0);
    run_frame(tbl[7]);
    check("timeout_no_wen", 64'(wen_total - wen0), 64'd0);

    // Reset after the fourth byte of a WRITE.
    wen0 = wen_total; tx0 = tx_total;
    send_byte(8'h01); send_byte(8'h05); send_byte(8'h00); send_byte(8'h25);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midreset_outputs", {bus.o_tx_valid, bus.o_wen, bus.o_start, bus.o_tx_data,
                               bus.o_waddr, bus.o_wcmd, bus.o_wdata}, 64'd0);
    check("midreset_rx_ready", 64'(bus.o_rx_ready), 64'd1);
    repeat (8) @(posedge clk);
    #1;
    check("midreset_no_tx", 64'(tx_total - tx0), 64'd0);
    check("midreset_no_wen", 64'(wen_total - wen0), 64'd0);
    run_frame(tbl[6]);

    // Randomized frames against the reference model.
    for (int r = 0; r < 40; r++) begin
      for (int k = 0; k < 8; k++) bb[k] = 8'($urandom_range(0, 255));
      case ($urandom_range(0, 3))
        0: begin bb[0] = 8'h01; bb[2] = 8'($urandom_range(0, 3)); len = 8; end
        1: begin bb[0] = 8'h02; len = 1; end
        2: begin bb[0] = 8'h03; len = 1; end
        default: begin bb[0] = 8'($urandom_range(4, 255)); len = 1; end
      endcase
      fr = {bb[0], bb[1], bb[2], bb[3], bb[4], bb[5], bb[6], bb[7]};
      v = model(fr, len, 1'($urandom_range(0, 1)));
      run_frame(v);
    end

    check("wen_start_exclusive", 64'(both_total), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
